hdmi_capture_yuv422: RTL and testbench
======================================

// Module: hdmi_capture_yuv422
// PURPOSE
// - Receive end of our 16-bit YCbCr 4:2:2 HDMI parallel video bus (vs/hs/de/d).
// - Rebuilds 24-bit YCbCr 4:4:4 pixels, decimates by 2^scale, and drives frame-buffer
//   write ports (addr/data/en) shaped exactly like the yuv422_fb write side.
// - Used for loopback of our own transmitter, and for capture from an external ADV-class receiver.
// PARAMETERS
// ACTIVE_H_PIXELS  1280  active pixels per line (expected de-high length)
// ACTIVE_LINES     720   active lines per frame (expected de-high lines)
// FRAME_X_SCALE    0     horizontal decimation, keep 1 of 2^N pixels
// FRAME_Y_SCALE    0     vertical decimation, keep 1 of 2^N lines
// SYNC_ACT_HIGH    1     1: vs_i active high; 0: active low
// FB_X/FB_Y        local ACTIVE_H_PIXELS>>FRAME_X_SCALE, ACTIVE_LINES>>FRAME_Y_SCALE
// FB_ADDR_BITS     local $clog2(FB_X*FB_Y)
// PORTS
// clk_i        in   1     pixel clock; the only clock
// rst_i        in   1     asynchronous, active-high reset
// en_i         in   1     capture enable
// vs_i         in   1     vertical sync
// de_i         in   1     data enable (active video)
// d_i          in   16    [15:8]=Y, [7:0]=C (Cb on even x, Cr on odd x)
// err_clr_i    in   1     1-cycle pulse, clears sticky error flags
// pxl_addr_o   out  FB_ADDR_BITS  frame-buffer write address
// pxl_data_o   out  24    {Y,Cb,Cr}
// pxl_en_o     out  1     write strobe
// frame_start_o out 1     1-cycle pulse, first active line begins
// frame_done_o out  1     1-cycle pulse at vs assertion closing a captured frame
// locked_o     out  1     high while in CAPTURE
// line_err_o   out  1     sticky: some line de-length != ACTIVE_H_PIXELS
// frame_err_o  out  1     sticky: frame line count != ACTIVE_LINES
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, pipeline flushed; reset mid-frame aborts with no further writes.
// - vs_i, de_i and d_i are registered once on input; the FSM acts on registered values.
// - vs_act = SYNC_ACT_HIGH ? vs : ~vs; edges are detected on the registered signal.
// - FSM:
//   IDLE -> WAIT_VS when en_i=1.
//   WAIT_VS -> WAIT_VS_END on vs_act rise.
//   WAIT_VS_END -> CAPTURE on vs_act fall; clear x, y.
//   CAPTURE -> WAIT_VS_END on vs_act rise; pulse frame_done_o; frame_err_o|=(y!=ACTIVE_LINES).
//   At that point, if en_i=0, go to IDLE instead.
//   en_i=0 mid-frame: current frame completes, then IDLE.
// - CAPTURE: x counts de-high cycles from 0. On de fall: line_err_o|=(x!=ACTIVE_H_PIXELS); y++.
//   frame_start_o pulses on the first de rise after entry.
// - Chroma: even x keeps Cb; Cr is taken from x+1. Odd x uses the pair's Cb and Cr.
//   A pair cut short by de falling on an even x uses Cr=8'h80.
// - Latency: fixed 3 clk from input sample of a pixel to its pxl_en_o (1 input reg + 2 upsampler).
// - Write gating: pxl_en_o=1 only when all of these hold:
//   x[FRAME_X_SCALE-1:0]==0, y[FRAME_Y_SCALE-1:0]==0, x<ACTIVE_H_PIXELS, y<ACTIVE_LINES.
//   Overlong lines and frames are never written out of range.
// - Address: running counters, no multiplier.
//   Line base += FB_X per kept line; addr = base + (x>>FRAME_X_SCALE). Resets to 0 each frame.
// - Simultaneous err_clr_i and new error: the error wins (flag stays set).
// - vs rising while de is high: the line is closed as on a de fall (line check and y++),
//   then the frame is closed.
// STRUCTURE
// - Package hdmi_cap_pkg:
//   cap_state_e {IDLE, WAIT_VS, WAIT_VS_END, CAPTURE};
//   Y_MSB/Y_LSB/C_MSB/C_LSB field constants; CHROMA_NEUTRAL=8'h80.
// - Sub-module yuv422_to_444: 2-stage chroma upsampler carrying valid, x-parity and last flags.
// - Top holds the input regs, FSM, counters, gating and address generation.
// TESTING
// 1 Loopback: our transmitter, 1280x720 scale 0, ramp pattern -> 921600 writes per frame,
//   addr 0..921599 in order; frame_done_o once; no errors.
// 2 Chroma: pair d=16'h1040,16'h20C0 -> pxl_data 24'h1040C0 then 24'h2040C0, 3 clk after each sample.
// 3 Scale X=1,Y=1: 1280x720 -> 230400 writes; addr of line 2 pixel 4 = 642.
// 4 Short line, 1279 de cycles -> line_err_o=1 until err_clr_i; last pixel Cr=8'h80.
// 5 Frame of 721 lines -> frame_err_o=1; no pxl_en_o for y=720.
// 6 rst_i mid-line (x=500) -> outputs 0 next edge; capture restarts only after a full vs pulse.

Source files
------------

// File: rtl/hdmi_cap_pkg.sv
// hdmi_cap_pkg: shared state encoding and bus field layout for the HDMI 4:2:2 capture path
package hdmi_cap_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_VS_END, CAPTURE} cap_state_e;
  localparam int Y_MSB = 15;
  localparam int Y_LSB = 8;
  localparam int C_MSB = 7;
  localparam int C_LSB = 0;
  localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;
endpackage

// File: rtl/yuv422_to_444.sv
// yuv422_to_444: two-stage 4:2:2 -> 4:4:4 chroma upsampler with a pass-through tag
module yuv422_to_444
  import hdmi_cap_pkg::*;
#(
  parameter int TW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid,
  input  logic          in_odd,
  input  logic [15:0]   in_d,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [23:0]   out_data,
  output logic [TW-1:0] out_tag
);
  logic          s1_valid, s1_odd;
  logic [15:0]   s1_d;
  logic [TW-1:0] s1_tag;
  logic [7:0]    cb_hold, cb, cr;
  // an even pixel borrows Cr from the odd pixel still sitting in the input slot
  always_comb begin
    cb = s1_odd ? cb_hold : s1_d[C_MSB:C_LSB];
    cr = s1_odd ? s1_d[C_MSB:C_LSB] : (in_valid & in_odd) ? in_d[C_MSB:C_LSB] : CHROMA_NEUTRAL;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {s1_valid, s1_odd, s1_d, s1_tag} <= '0;
      cb_hold <= '0;
      {out_valid, out_data, out_tag} <= '0;
    end else begin
      {s1_valid, s1_odd, s1_d, s1_tag} <= {in_valid, in_odd, in_d, in_tag};
      if (s1_valid & ~s1_odd) cb_hold <= s1_d[C_MSB:C_LSB];
      out_valid <= s1_valid;
      out_data <= {s1_d[Y_MSB:Y_LSB], cb, cr};
      out_tag <= s1_tag;
    end
  end
endmodule

// File: rtl/hdmi_capture_yuv422.sv
// hdmi_capture_yuv422: 4:2:2 HDMI bus capture to decimated 4:4:4 frame-buffer writes
module hdmi_capture_yuv422
  import hdmi_cap_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES = 720,
  parameter int FRAME_X_SCALE = 0,
  parameter int FRAME_Y_SCALE = 0,
  parameter int SYNC_ACT_HIGH = 1,
  localparam int FB_X = ACTIVE_H_PIXELS >> FRAME_X_SCALE,
  localparam int FB_Y = ACTIVE_LINES >> FRAME_Y_SCALE,
  localparam int FB_ADDR_BITS = $clog2(FB_X * FB_Y)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    vs_i,
  input  logic                    de_i,
  input  logic [15:0]             d_i,
  input  logic                    err_clr_i,
  output logic [FB_ADDR_BITS-1:0] pxl_addr_o,
  output logic [23:0]             pxl_data_o,
  output logic                    pxl_en_o,
  output logic                    frame_start_o,
  output logic                    frame_done_o,
  output logic                    locked_o,
  output logic                    line_err_o,
  output logic                    frame_err_o
);
  localparam int XW = $clog2(ACTIVE_H_PIXELS + 2) + 1;
  localparam int YW = $clog2(ACTIVE_LINES + 2) + 1;
  localparam logic [XW-1:0] H_L = XW'(ACTIVE_H_PIXELS);
  localparam logic [YW-1:0] V_L = YW'(ACTIVE_LINES);
  localparam logic [XW-1:0] X_MASK = XW'((1 << FRAME_X_SCALE) - 1);
  localparam logic [YW-1:0] Y_MASK = YW'((1 << FRAME_Y_SCALE) - 1);
  localparam logic [FB_ADDR_BITS-1:0] FB_X_L = FB_ADDR_BITS'(FB_X);

  cap_state_e              state, state_nxt;
  logic                    vs_a, vs_p, de_r, de_p;
  logic [15:0]             d_r;
  logic [XW-1:0]           x, x_inc, len;
  logic [YW-1:0]           y, y_nxt;
  logic [FB_ADDR_BITS-1:0] base, addr;
  logic                    started, capture, vs_rise, vs_fall, close, y_kept, wr, up_valid;
  logic [FB_ADDR_BITS:0]   up_tag;

  // a vs rise with de still high closes the line as if de had fallen
  always_comb begin
    capture = state == CAPTURE;
    vs_rise = vs_a & ~vs_p;
    vs_fall = vs_p & ~vs_a;
    close = capture & ((de_p & ~de_r) | (vs_rise & de_r));
    x_inc = &x ? x : x + 1'b1;
    len = de_r ? x_inc : x;
    y_nxt = (close & ~&y) ? y + 1'b1 : y;
    y_kept = ((y & Y_MASK) == '0) & (y < V_L);
    wr = capture & de_r & y_kept & ((x & X_MASK) == '0) & (x < H_L);
    addr = base + FB_ADDR_BITS'(x >> FRAME_X_SCALE);
    state_nxt = (state == IDLE && en_i) ? WAIT_VS :
                (state == WAIT_VS && vs_rise) ? WAIT_VS_END :
                (state == WAIT_VS_END && vs_fall) ? CAPTURE :
                (capture && vs_rise) ? (en_i ? WAIT_VS_END : IDLE) : state;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      {vs_a, vs_p, de_r, de_p, d_r} <= '0;
      x <= '0;
      y <= '0;
      base <= '0;
      started <= 1'b0;
      {frame_start_o, frame_done_o, line_err_o, frame_err_o} <= '0;
    end else begin
      state <= state_nxt;
      vs_a <= (SYNC_ACT_HIGH != 0) ? vs_i : ~vs_i;
      vs_p <= vs_a;
      de_r <= de_i;
      de_p <= de_r;
      d_r <= d_i;
      if (state == WAIT_VS_END && vs_fall) begin
        x <= '0;
        y <= '0;
        base <= '0;
        started <= 1'b0;
      end else if (capture) begin
        x <= de_r ? x_inc : '0;
        y <= y_nxt;
        if (close && y_kept) base <= base + FB_X_L;
        if (de_r && !de_p) started <= 1'b1;
      end
      frame_start_o <= capture & de_r & ~de_p & ~started;
      frame_done_o <= capture & vs_rise;
      line_err_o <= (close & (len != H_L)) | (line_err_o & ~err_clr_i);
      frame_err_o <= (capture & vs_rise & (y_nxt != V_L)) | (frame_err_o & ~err_clr_i);
    end
  end

  yuv422_to_444 #(.TW(FB_ADDR_BITS + 1)) u_up (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .in_valid(capture & de_r),
    .in_odd(x[0]),
    .in_d(d_r),
    .in_tag({wr, addr}),
    .out_valid(up_valid),
    .out_data(pxl_data_o),
    .out_tag(up_tag)
  );

  assign pxl_en_o = up_valid & up_tag[FB_ADDR_BITS];
  assign pxl_addr_o = up_tag[FB_ADDR_BITS-1:0];
  assign locked_o = capture;
endmodule

// File: tb/tb_hdmi_capture_yuv422.sv
// tb_hdmi_capture_yuv422: directed frames on an 8x4 raster, full-rate and 2x2-decimated instances
module tb_hdmi_capture_yuv422;
  localparam int H = 8;
  localparam int V = 4;

  typedef struct {
    int due;
    logic [7:0] addr;
    logic [23:0] data;
  } exp_t;

  typedef struct {
    int nlines;
    int bad_y;
    int bad_len;
    bit lerr;
    bit ferr;
    int w0;
    int w1;
  } row_t;

  logic clk = 0, rst = 1, en = 0, vs = 0, de = 0, err_clr = 0;
  logic [15:0] d = '0;
  logic pe0, fs0, fd0, lk0, le0, fe0, pe1, fs1, fd1, lk1, le1, fe1;
  logic [4:0] pa0;
  logic [2:0] pa1;
  logic [23:0] pd0, pd1;

  int checks = 0, failures = 0, cyc = 0, w0 = 0, w1 = 0, nd = 0, ns = 0;
  exp_t q0[$], q1[$];
  row_t rows[6];

  always #5 clk = ~clk;

  hdmi_capture_yuv422 #(.ACTIVE_H_PIXELS(H), .ACTIVE_LINES(V)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vs_i(vs), .de_i(de), .d_i(d), .err_clr_i(err_clr),
    .pxl_addr_o(pa0), .pxl_data_o(pd0), .pxl_en_o(pe0), .frame_start_o(fs0), .frame_done_o(fd0),
    .locked_o(lk0), .line_err_o(le0), .frame_err_o(fe0));

  hdmi_capture_yuv422 #(.ACTIVE_H_PIXELS(H), .ACTIVE_LINES(V), .FRAME_X_SCALE(1), .FRAME_Y_SCALE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vs_i(vs), .de_i(de), .d_i(d), .err_clr_i(err_clr),
    .pxl_addr_o(pa1), .pxl_data_o(pd1), .pxl_en_o(pe1), .frame_start_o(fs1), .frame_done_o(fd1),
    .locked_o(lk1), .line_err_o(le1), .frame_err_o(fe1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    w0 += int'(pe0);
    w1 += int'(pe1);
    nd += int'(fd0);
    ns += int'(fs0);
    if (q0.size() > 0 && q0[0].due <= cyc) begin
      e = q0.pop_front();
      checks++;
      if (e.due != cyc || !pe0 || 8'(pa0) != e.addr || pd0 != e.data) begin
        failures++;
        $display("FAIL pix0 cyc=%0d en=%b addr=%0d data=%h expected addr=%0d data=%h at cyc %0d",
                 cyc, pe0, pa0, pd0, e.addr, e.data, e.due);
      end
    end else if (pe0) begin
      checks++;
      failures++;
      $display("FAIL pix0 unexpected write cyc=%0d addr=%0d data=%h", cyc, pa0, pd0);
    end
    if (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      checks++;
      if (e.due != cyc || !pe1 || 8'(pa1) != e.addr || pd1 != e.data) begin
        failures++;
        $display("FAIL pix1 cyc=%0d en=%b addr=%0d data=%h expected addr=%0d data=%h at cyc %0d",
                 cyc, pe1, pa1, pd1, e.addr, e.data, e.due);
      end
    end else if (pe1) begin
      checks++;
      failures++;
      $display("FAIL pix1 unexpected write cyc=%0d addr=%0d data=%h", cyc, pa1, pd1);
    end
  endtask

  task automatic step(input logic v, input logic e, input logic [15:0] dd);
    vs = v;
    de = e;
    d = dd;
    @(posedge clk);
    cyc++;
    #1;
    monitor();
  endtask

  function automatic logic [15:0] pix(input int y, input int x);
    logic [7:0] yy, cc;
    yy = 8'(y * 16 + x);
    cc = (x % 2 == 1) ? 8'(8'hC0 + x) : 8'(8'h40 + x);
    return {yy, cc};
  endfunction

  task automatic push(input int y, input int x, input int len);
    logic [15:0] p, q;
    logic [7:0] cb, cr;
    exp_t e;
    p = pix(y, x);
    q = (x % 2 == 1) ? pix(y, x - 1) : pix(y, x + 1);
    cb = (x % 2 == 1) ? q[7:0] : p[7:0];
    cr = (x % 2 == 1) ? p[7:0] : ((x + 1 < len) ? q[7:0] : 8'h80);
    e.due = cyc + 3;
    e.data = {p[15:8], cb, cr};
    if (x < H && y < V) begin
      e.addr = 8'(y * H + x);
      q0.push_back(e);
    end
    if (x < H && y < V && x % 2 == 0 && y % 2 == 0) begin
      e.addr = 8'((y / 2) * (H / 2) + x / 2);
      q1.push_back(e);
    end
  endtask

  task automatic line(input int y, input int len, input bit cap);
    for (int x = 0; x < len; x++) begin
      if (cap) push(y, x, len);
      step(0, 1, pix(y, x));
    end
    step(0, 0, '0);
    step(0, 0, '0);
  endtask

  task automatic frame(input int n, input int bad_y, input int bad_len, input bit cap);
    for (int y = 0; y < n; y++) line(y, (y == bad_y) ? bad_len : H, cap);
  endtask

  task automatic vs_pulse();
    step(1, 0, '0);
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 0, '0);
  endtask

  task automatic clear_errs();
    err_clr = 1;
    step(0, 0, '0);
    err_clr = 0;
    step(0, 0, '0);
  endtask

  task automatic zero_counts();
    w0 = 0;
    w1 = 0;
    nd = 0;
    ns = 0;
  endtask

  initial begin
    rows[0] = '{4, -1, H, 1'b0, 1'b0, 32, 8};
    rows[1] = '{4, 1, 7, 1'b1, 1'b0, 31, 8};
    rows[2] = '{5, -1, H, 1'b0, 1'b1, 32, 8};
    rows[3] = '{3, -1, H, 1'b0, 1'b1, 24, 8};
    rows[4] = '{4, 2, 9, 1'b1, 1'b0, 32, 8};
    rows[5] = '{4, 0, 1, 1'b1, 1'b0, 25, 5};

    repeat (3) step(0, 0, '0);
    chk("reset0", int'(|{pe0, pa0, pd0, fs0, fd0, lk0, le0, fe0}), 0);
    chk("reset1", int'(|{pe1, pa1, pd1, fs1, fd1, lk1, le1, fe1}), 0);
    rst = 0;
    en = 1;
    step(0, 0, '0);
    vs_pulse();
    chk("locked_after_vs", int'(lk0), 1);

    for (int i = 0; i < 6; i++) begin
      zero_counts();
      frame(rows[i].nlines, rows[i].bad_y, rows[i].bad_len, 1'b1);
      vs_pulse();
      repeat (3) step(0, 0, '0);
      chk($sformatf("row%0d_writes0", i), w0, rows[i].w0);
      chk($sformatf("row%0d_writes1", i), w1, rows[i].w1);
      chk($sformatf("row%0d_frame_done", i), nd, 1);
      chk($sformatf("row%0d_frame_start", i), ns, 1);
      chk($sformatf("row%0d_line_err", i), int'(le0), int'(rows[i].lerr));
      chk($sformatf("row%0d_frame_err", i), int'(fe0), int'(rows[i].ferr));
      chk($sformatf("row%0d_frame_err1", i), int'(fe1), int'(rows[i].ferr));
      clear_errs();
      chk($sformatf("row%0d_cleared", i), int'(le0 | fe0), 0);
    end

    // clear pulse landing on the same edge as a new short-line error
    zero_counts();
    for (int x = 0; x < 7; x++) begin
      push(0, x, 7);
      step(0, 1, pix(0, x));
    end
    step(0, 0, '0);
    err_clr = 1;
    step(0, 0, '0);
    err_clr = 0;
    step(0, 0, '0);
    chk("clr_vs_new_err", int'(le0), 1);
    for (int y = 1; y < V; y++) line(y, H, 1'b1);
    vs_pulse();
    repeat (3) step(0, 0, '0);
    chk("clr_frame_err", int'(fe0), 0);
    chk("clr_writes0", w0, 31);
    clear_errs();

    // disable mid-frame: the frame completes, then capture stops
    zero_counts();
    step(0, 0, '0);
    en = 0;
    frame(V, -1, H, 1'b1);
    vs_pulse();
    repeat (3) step(0, 0, '0);
    chk("dis_writes0", w0, 32);
    chk("dis_done", nd, 1);
    chk("dis_locked", int'(lk0), 0);
    zero_counts();
    vs_pulse();
    line(0, H, 1'b0);
    chk("dis_no_writes", w0 + w1, 0);

    // reset mid-line, then no capture until a full vs pulse
    en = 1;
    step(0, 0, '0);
    vs_pulse();
    for (int x = 0; x < 5; x++) begin
      push(0, x, H);
      step(0, 1, pix(0, x));
    end
    rst = 1;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_mid0", int'(|{pe0, pa0, pd0, fs0, fd0, lk0, le0, fe0}), 0);
    step(0, 1, pix(0, 5));
    chk("rst_mid_edge", int'(|{pe0, pa0, pd0, lk0, pe1, lk1}), 0);
    rst = 0;
    zero_counts();
    line(0, H, 1'b0);
    line(1, H, 1'b0);
    chk("rst_no_capture", w0 + w1, 0);
    chk("rst_not_locked", int'(lk0), 0);
    vs_pulse();
    frame(V, -1, H, 1'b1);
    vs_pulse();
    repeat (3) step(0, 0, '0);
    chk("rst_writes0", w0, 32);
    chk("rst_writes1", w1, 8);
    chk("rst_errs", int'(le0 | fe0), 0);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
